// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: datapath width, canonical NOP, major opcodes.
// Latency: none (declarations only).
// Backpressure: not applicable.
// Imported by the fetch unit, its bus interface and the control unit.
package riscv_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OPC_R = 7'b0110011;
  localparam logic [6:0] OPC_I = 7'b0010011;
  localparam logic [6:0] OPC_S = 7'b0100011;
  localparam logic [6:0] OPC_L = 7'b0000011;
  localparam logic [6:0] OPC_B = 7'b1100011;

  // Field handed from decode to the control unit.
  function automatic logic [6:0] opcode_of(input logic [31:0] ins);
    return ins[6:0];
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction memory port, decode handshake, redirect input.
// Latency: none (wires only).
// Backpressure: decode stalls via instr_ready; memory accepts every request.
// master = fetch unit side, slave = memory/decode/execute side.
interface instr_fetch_unit_if #(
  parameter int XLEN = riscv_pkg::XLEN
);
  import riscv_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;
  logic            instr_valid;
  logic [31:0]     instr;
  logic [XLEN-1:0] instr_pc;
  logic            instr_ready;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            fetch_misaligned;

  modport master (
    output imem_req, imem_addr,
    input  imem_rvalid, imem_rdata,
    output instr_valid, instr, instr_pc,
    input  instr_ready,
    input  redirect_valid, redirect_pc,
    output fetch_misaligned
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_rvalid, imem_rdata,
    input  instr_valid, instr, instr_pc,
    output instr_ready,
    output redirect_valid, redirect_pc,
    input  fetch_misaligned
  );

endinterface

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO with flush; flush beats push and pop.
// Latency: a pushed word is visible at pop_dat the cycle after the push.
// Backpressure: push ignored when full unless a pop happens in the same cycle.
// Ports: clk, rst_n, push/push_dat, pop/pop_dat, flush, full, empty, count.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_dat,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_dat,
  input  logic                   flush,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign pop_dat = mem[rd_ptr];

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// RISC-V fetch front end: owns the PC, issues in-order word fetches, buffers returns for decode.
// Latency: request in the first cycle out of reset; with 1-cycle memory instr_valid two cycles later.
// Backpressure: requests are credit-limited by buffered + in-flight words; decode stalls via instr_ready.
// Ports: clk, rst_n, bus (instr_fetch_unit_if.master: imem req/addr/rvalid/rdata,
//        instr_valid/instr/instr_pc/instr_ready, redirect_valid/redirect_pc, fetch_misaligned).
// Build option: FETCH_ALIGN_CHECK_EN enables the sticky misaligned-redirect trap;
//        without it the low two bits of redirect_pc are dropped.
module instr_fetch_unit #(
  parameter int              XLEN       = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 2
) (
  input logic                clk,
  input logic                rst_n,
  instr_fetch_unit_if.master bus
);
  import riscv_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_V = (CW+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } entry_t;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] resp_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   discard;
  logic [CW-1:0]   fifo_count;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW:0]     used;
  logic            halted;
  logic            req;
  logic            push;
  logic            pop;
  logic [XLEN-1:0] target;
  entry_t          push_entry;
  entry_t          head;

  // Every slot is either holding a word or reserved by an in-flight request,
  // so the FIFO can never be pushed while full.
  assign used = {1'b0, fifo_count} + {1'b0, outstanding};
  assign req  = rst_n && (used < DEPTH_V) && !bus.redirect_valid && !halted;

  // Responses in a redirect cycle are stale; so are those counted by discard.
  assign push = bus.imem_rvalid && !bus.redirect_valid && (discard == '0);
  assign pop  = bus.instr_valid && bus.instr_ready;

  assign push_entry = '{pc: resp_pc, instr: bus.imem_rdata};

`ifdef FETCH_ALIGN_CHECK_EN
  logic misaligned;

  assign target = bus.redirect_pc;
  assign halted = misaligned;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  misaligned <= 1'b0;
    else if (bus.redirect_valid) misaligned <= |bus.redirect_pc[1:0];
  end

  assign bus.fetch_misaligned = misaligned;
`else
  assign target = bus.redirect_pc & ~XLEN'(3);
  assign halted = 1'b0;
  assign bus.fetch_misaligned = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding + CW'(req) - CW'(bus.imem_rvalid);
      if (bus.redirect_valid) begin
        pc      <= target;
        resp_pc <= target;
        // Everything still in flight after this cycle belongs to the old
        // stream. discard only ever counts a subset of outstanding, so the
        // in-flight count alone is the new drop budget.
        discard <= outstanding - CW'(bus.imem_rvalid);
      end else begin
        if (req) pc <= pc + XLEN'(4);
        if (bus.imem_rvalid) begin
          if (discard != '0) discard <= discard - CW'(1);
          else               resp_pc <= resp_pc + XLEN'(4);
        end
      end
    end
  end

  fetch_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat (push_entry),
    .pop      (pop),
    .pop_dat  (head),
    .flush    (bus.redirect_valid),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign bus.imem_req    = req;
  assign bus.imem_addr   = pc;
  assign bus.instr_valid = !fifo_empty;
  assign bus.instr       = fifo_empty ? NOP_INSTR : head.instr;
  assign bus.instr_pc    = fifo_empty ? RESET_PC  : head.pc;

  a_resp_expected: assert property (@(posedge clk) disable iff (!rst_n)
    bus.imem_rvalid |-> (outstanding != '0));

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && fifo_full && !pop));

endmodule
